// File: rtl/mem_arb_pkg.sv
// Shared encodings and width defaults for the I/D memory-port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RESP  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/arb_pick.sv
// Combinational grant selector: fixed D-over-I priority by default,
// round-robin against the last owner when MEM_ARB_RR_EN is defined.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic   i_valid,
    input  logic   d_valid,
    input  owner_e last_owner,
    output logic   grant_valid,
    output owner_e grant_owner
);

    assign grant_valid = i_valid | d_valid;

`ifdef MEM_ARB_RR_EN
    always_comb begin
        grant_owner = OWN_I;
        if (i_valid && d_valid) begin
            grant_owner = (last_owner == OWN_D) ? OWN_I : OWN_D;
        end else if (d_valid) begin
            grant_owner = OWN_D;
        end
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    always_comb begin
        grant_owner = OWN_I;
        if (d_valid) begin
            grant_owner = OWN_D;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one word-wide memory port between I-cache and D-cache requesters.
// Optional MEM_ARB_RR_EN selects round-robin instead of fixed D-over-I priority.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   ARB_IDLE  | no transaction; grant on any valid
//   ARB_ISSUE | mem_req_valid high, waiting for mem_req_ready or timeout
//   ARB_RESP  | one-cycle ready pulse to the owner, then back to idle
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    input  logic              i_req_wr,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              i_req_ready,
    output logic [DATA_W-1:0] i_req_rdata,
    input  logic              d_req_valid,
    input  logic              d_req_wr,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_req_ready,
    output logic [DATA_W-1:0] d_req_rdata,
    output logic              mem_req_valid,
    output logic              mem_req_wr,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_req_data,
    input  logic              mem_req_ready,
    output logic              err_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_e       state, state_nxt;
    owner_e           owner, last_owner, grant_owner;
    logic             grant_valid;
    logic             grant_take, issue_done, issue_abort;
    logic [CNT_W-1:0] cnt;

    // The owner register doubles as the round-robin pointer; the fixed
    // priority build ties the pointer off so no extra state exists.
`ifdef MEM_ARB_RR_EN
    assign last_owner = owner;
`else
    assign last_owner = OWN_I;
`endif

    arb_pick u_pick (
        .i_valid     (i_req_valid),
        .d_valid     (d_req_valid),
        .last_owner  (last_owner),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        grant_take  = 1'b0;
        issue_done  = 1'b0;
        issue_abort = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (grant_valid) begin
                    grant_take = 1'b1;
                    state_nxt  = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (mem_req_ready) begin
                    issue_done = 1'b1;
                    state_nxt  = ARB_RESP;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    issue_abort = 1'b1;
                    state_nxt   = ARB_RESP;
                end
            end
            ARB_RESP: begin
                state_nxt = ARB_IDLE;
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner         <= OWN_I;
            cnt           <= '0;
            mem_req_valid <= 1'b0;
            mem_req_wr    <= 1'b0;
            mem_req_addr  <= '0;
            mem_wr_data   <= '0;
            i_req_ready   <= 1'b0;
            d_req_ready   <= 1'b0;
            i_req_rdata   <= '0;
            d_req_rdata   <= '0;
            err_timeout   <= 1'b0;
        end else begin
            i_req_ready <= 1'b0;
            d_req_ready <= 1'b0;

            if (grant_take) begin
                owner         <= grant_owner;
                cnt           <= '0;
                mem_req_valid <= 1'b1;
                if (grant_owner == OWN_D) begin
                    mem_req_wr   <= d_req_wr;
                    mem_req_addr <= d_req_addr;
                    mem_wr_data  <= d_req_wdata;
                end else begin
                    mem_req_wr   <= i_req_wr;
                    mem_req_addr <= i_req_addr;
                    mem_wr_data  <= i_req_wdata;
                end
            end

            if (state == ARB_ISSUE) begin
                cnt <= cnt + 1'b1;
            end

            // An aborted transaction still completes toward the cache, with zero data.
            if (issue_done || issue_abort) begin
                mem_req_valid <= 1'b0;
                if (owner == OWN_D) begin
                    d_req_ready <= 1'b1;
                    d_req_rdata <= issue_done ? mem_req_data : '0;
                end else begin
                    i_req_ready <= 1'b1;
                    i_req_rdata <= issue_done ? mem_req_data : '0;
                end
            end

            if (issue_abort) begin
                err_timeout <= 1'b1;
            end

            if (state == ARB_RESP) begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (TIMEOUT=8), with a small memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid, i_req_wr, d_req_valid, d_req_wr;
    logic [31:0] i_req_addr, i_req_wdata, d_req_addr, d_req_wdata;
    logic        i_req_ready, d_req_ready;
    logic [31:0] i_req_rdata, d_req_rdata;
    logic        mem_req_valid, mem_req_wr, mem_req_ready;
    logic [31:0] mem_req_addr, mem_wr_data, mem_req_data;
    logic        err_timeout;

    int checks   = 0;
    int failures = 0;
    int mem_lat  = 0;
    int mv_cnt   = 0;
    logic [31:0] mem_data = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_req_valid   (i_req_valid),
        .i_req_wr      (i_req_wr),
        .i_req_addr    (i_req_addr),
        .i_req_wdata   (i_req_wdata),
        .i_req_ready   (i_req_ready),
        .i_req_rdata   (i_req_rdata),
        .d_req_valid   (d_req_valid),
        .d_req_wr      (d_req_wr),
        .d_req_addr    (d_req_addr),
        .d_req_wdata   (d_req_wdata),
        .d_req_ready   (d_req_ready),
        .d_req_rdata   (d_req_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_wr    (mem_req_wr),
        .mem_req_addr  (mem_req_addr),
        .mem_wr_data   (mem_wr_data),
        .mem_req_data  (mem_req_data),
        .mem_req_ready (mem_req_ready),
        .err_timeout   (err_timeout)
    );

    typedef struct {
        logic        is_d;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mdata;
        int          lat;        // mem_req_ready in cycle T+lat; 0 = never
        logic [31:0] exp_rdata;
        int          exp_cyc;    // cycle offset of the ready pulse
        logic        exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Memory answers in the lat-th cycle that mem_req_valid is seen high.
    task automatic mem_step();
        if (mem_req_valid) begin
            mv_cnt++;
            mem_req_ready = (mem_lat != 0) && (mv_cnt == mem_lat);
        end else begin
            mv_cnt        = 0;
            mem_req_ready = 1'b0;
        end
        mem_req_data = mem_data;
    endtask

    task automatic run_vec(input vec_t v);
        logic seen;
        logic own_rdy, oth_rdy;
        logic [31:0] own_rdata;
        seen     = 1'b0;
        mem_lat  = v.lat;
        mem_data = v.mdata;
        if (v.is_d) begin
            d_req_valid = 1'b1; d_req_wr = v.wr; d_req_addr = v.addr; d_req_wdata = v.wdata;
        end else begin
            i_req_valid = 1'b1; i_req_wr = v.wr; i_req_addr = v.addr; i_req_wdata = v.wdata;
        end
        for (int cyc = 1; cyc <= 30 && !seen; cyc++) begin
            cycle();
            mem_step();
            if (mem_req_valid) begin
                chk("mem_fields", {mem_req_wr, mem_req_addr, mem_wr_data[30:0]},
                    {v.wr, v.addr, v.wdata[30:0]});
            end
            own_rdy   = v.is_d ? d_req_ready : i_req_ready;
            oth_rdy   = v.is_d ? i_req_ready : d_req_ready;
            own_rdata = v.is_d ? d_req_rdata : i_req_rdata;
            if (own_rdy) begin
                seen = 1'b1;
                chk("ready_cycle", 64'(cyc), 64'(v.exp_cyc));
                chk("rdata", {32'h0, own_rdata}, {32'h0, v.exp_rdata});
                chk("other_ready", {63'h0, oth_rdy}, 64'h0);
                chk("err_timeout", {63'h0, err_timeout}, {63'h0, v.exp_err});
                i_req_valid = 1'b0;
                d_req_valid = 1'b0;
            end
        end
        if (!seen) begin
            chk("ready_wait", 64'h0, 64'h1);
            i_req_valid = 1'b0;
            d_req_valid = 1'b0;
        end
        cycle();
        mem_step();
        chk("ready_one_cycle", {62'h0, i_req_ready, d_req_ready}, 64'h0);
    endtask

    // Both requesters raise valid in the same cycle; the first winner's ready
    // lands at T+3 (lat 2) and the second at T+7 after one idle cycle.
    task automatic collision(input logic exp_d_first, input logic [31:0] md);
        int d_cyc, i_cyc;
        logic d_done, i_done;
        logic [31:0] exp_addr;
        d_cyc = 0; i_cyc = 0; d_done = 1'b0; i_done = 1'b0;
        mem_lat  = 2;
        mem_data = md;
        i_req_valid = 1'b1; i_req_wr = 1'b0; i_req_addr = 32'h0300; i_req_wdata = 32'h0;
        d_req_valid = 1'b1; d_req_wr = 1'b1; d_req_addr = 32'h0400; d_req_wdata = 32'h55AA_0F0F;
        for (int cyc = 1; cyc <= 30 && !(d_done && i_done); cyc++) begin
            cycle();
            mem_step();
            if (mem_req_valid) begin
                if (exp_d_first) exp_addr = (!d_done) ? 32'h0400 : 32'h0300;
                else             exp_addr = (!i_done) ? 32'h0300 : 32'h0400;
                chk("coll_addr", {32'h0, mem_req_addr}, {32'h0, exp_addr});
            end
            if (d_req_ready) begin d_done = 1'b1; d_cyc = cyc; d_req_valid = 1'b0; end
            if (i_req_ready) begin i_done = 1'b1; i_cyc = cyc; i_req_valid = 1'b0; end
        end
        chk("coll_d_cycle", 64'(d_cyc), exp_d_first ? 64'd3 : 64'd7);
        chk("coll_i_cycle", 64'(i_cyc), exp_d_first ? 64'd7 : 64'd3);
        chk("coll_i_rdata", {32'h0, i_req_rdata}, {32'h0, md});
        chk("coll_d_rdata", {32'h0, d_req_rdata}, {32'h0, md});
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        cycle();
        mem_step();
    endtask

    initial begin
        rst = 1'b1;
        i_req_valid = 1'b0; i_req_wr = 1'b0; i_req_addr = '0; i_req_wdata = '0;
        d_req_valid = 1'b0; d_req_wr = 1'b0; d_req_addr = '0; d_req_wdata = '0;
        mem_req_ready = 1'b0; mem_req_data = '0;

        //           is_d  wr    addr        wdata          mdata          lat exp_rdata     cyc err
        vecs[0] = '{1'b0, 1'b0, 32'h0040, 32'h0000_0000, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 4, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h0100, 32'h1234_5678, 32'hA5A5_A5A5, 2, 32'hA5A5_A5A5, 3, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'h0200, 32'h0000_0000, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, 2, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 32'h0044, 32'h0000_0000, 32'h0BAD_F00D, 5, 32'h0BAD_F00D, 6, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 32'h0500, 32'h0000_0000, 32'h7777_7777, 0, 32'h0000_0000, 9, 1'b1};

        cycle();
        cycle();
        chk("rst_mem", {mem_req_valid, mem_req_wr, mem_req_addr, mem_wr_data[29:0]}, 64'h0);
        chk("rst_ready", {61'h0, i_req_ready, d_req_ready, err_timeout}, 64'h0);
        chk("rst_rdata", {i_req_rdata, d_req_rdata}, 64'h0);
        rst = 1'b0;
        cycle();

        for (int k = 0; k < 5; k++) begin
            run_vec(vecs[k]);
        end

`ifdef MEM_ARB_RR_EN
        collision(1'b0, 32'h1111_2222);
        collision(1'b0, 32'h3333_4444);
`else
        collision(1'b1, 32'h1111_2222);
        collision(1'b1, 32'h3333_4444);
`endif

        // Stray memory completions in IDLE must not produce a ready pulse.
        for (int k = 0; k < 3; k++) begin
            mem_req_ready = 1'b1;
            cycle();
            chk("idle_ignore", {61'h0, mem_req_valid, i_req_ready, d_req_ready}, 64'h0);
        end
        mem_req_ready = 1'b0;
        chk("rdata_hold", {i_req_rdata, d_req_rdata}, {32'h3333_4444, 32'h3333_4444});

        // Reset in the middle of a transaction drops it and clears the sticky error.
        mem_lat = 0;
        i_req_valid = 1'b1; i_req_wr = 1'b0; i_req_addr = 32'h0080; i_req_wdata = '0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            mem_step();
        end
        chk("pre_rst_issue", {63'h0, mem_req_valid}, 64'h1);
        rst = 1'b1;
        i_req_valid = 1'b0;
        cycle();
        chk("mid_rst", {60'h0, mem_req_valid, i_req_ready, d_req_ready, err_timeout}, 64'h0);
        rst = 1'b0;
        cycle();
        chk("post_rst_idle", {63'h0, mem_req_valid}, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
